// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single memory port shared by instruction fetch and data
// load/store. Arbitrates, checks alignment/size, runs the addr_ok/data_ok
// handshake downstream and returns one registered response per request.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ready,
   output logic        i_resp_valid,
   output logic [31:0] i_rdata,
   output logic [1:0]  i_status,
   input  logic        d_req,
   input  logic        d_wen,
   input  logic [31:0] d_addr,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_wdata,
   output logic        d_ready,
   output logic        d_resp_valid,
   output logic [31:0] d_rdata,
   output logic [1:0]  d_status,
   output logic        m_req,
   output logic        m_wen,
   output logic [31:0] m_addr,
   output logic [1:0]  m_size,
   output logic [3:0]  m_strb,
   output logic [31:0] m_wdata,
   input  logic        m_addr_ok,
   input  logic        m_data_ok,
   input  logic [31:0] m_rdata
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
   typedef enum logic [1:0] {
      ST_OK       = 2'b00,
      ST_MISALIGN = 2'b01,
      ST_TIMEOUT  = 2'b10,
      ST_SIZE     = 2'b11
   } status_t;

   localparam int unsigned   CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t        state;
   logic          last_grant_d;   // 1 = data won the last accept, 0 = fetch
   logic          owner_d;        // requester owning the transaction in flight
   logic [CW-1:0] cnt;

   logic          grant_d, grant_i, accept, timeout_hit;
   logic          sel_wen;
   logic [31:0]   sel_addr, sel_wdata;
   logic [1:0]    sel_size;
   logic [3:0]    sel_strb;
   status_t       sel_status;

   logic          fin, fin_owner_d;
   status_t       fin_status;
   logic [31:0]   fin_rdata;

   // On a conflict the requester that did not win last time is granted.
   assign grant_d = d_req & (~i_req | ~last_grant_d);
   assign grant_i = i_req & ~grant_d;

   // NOTE: ready is gated by resetn so it stays low while reset is held,
   // even though the state register already reads IDLE.
   assign i_ready = (state == IDLE) & resetn & grant_i;
   assign d_ready = (state == IDLE) & resetn & grant_d;
   assign accept  = i_ready | d_ready;

   assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

   // Fields of the granted request, with alignment/size check and byte strobe.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      sel_wen    = grant_d ? d_wen : 1'b0;
      sel_addr   = grant_d ? d_addr : i_addr;
      sel_size   = grant_d ? d_size : 2'd2;
      sel_wdata  = grant_d ? d_wdata : 32'h0;
      sel_status = ST_OK;
      sel_strb   = 4'b0000;
      case (sel_size)
         2'd1:    if (sel_addr[0])          sel_status = ST_MISALIGN;
         2'd2:    if (sel_addr[1:0] != 2'd0) sel_status = ST_MISALIGN;
         2'd3:    sel_status = ST_SIZE;
         default: sel_status = ST_OK;
      endcase
      if (sel_wen) begin
         case (sel_size)
            2'd0:    sel_strb = 4'b0001 << sel_addr[1:0];
            2'd1:    sel_strb = 4'b0011 << sel_addr[1:0];
            default: sel_strb = 4'b1111;
         endcase
      end
   end

   // Decide whether the current cycle ends a request, and with what result.
   always_comb begin
      fin         = 1'b0;
      fin_status  = ST_OK;
      fin_rdata   = 32'h0;
      fin_owner_d = (state == IDLE) ? grant_d : owner_d;
      case (state)
         IDLE: begin
            if (accept && sel_status != ST_OK) begin
               fin        = 1'b1;
               fin_status = sel_status;
            end
         end
         ADDR: begin
            if (m_addr_ok && m_data_ok) begin
               fin       = 1'b1;
               fin_rdata = m_wen ? 32'h0 : m_rdata;
            end else if (!m_addr_ok && timeout_hit) begin
               fin        = 1'b1;
               fin_status = ST_TIMEOUT;
            end
         end
         DATA: begin
            if (m_data_ok) begin
               fin       = 1'b1;
               fin_rdata = m_wen ? 32'h0 : m_rdata;
            end else if (timeout_hit) begin
               fin        = 1'b1;
               fin_status = ST_TIMEOUT;
            end
         end
         default: fin = 1'b0;
      endcase
   end

   // Transaction FSM with registered downstream request fields.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         last_grant_d <= 1'b0;
         owner_d      <= 1'b0;
         cnt          <= '0;
         m_req        <= 1'b0;
         m_wen        <= 1'b0;
         m_addr       <= 32'h0;
         m_size       <= 2'd0;
         m_strb       <= 4'b0000;
         m_wdata      <= 32'h0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         case (state)
            IDLE: begin
               if (accept) begin
                  last_grant_d <= grant_d;
                  owner_d      <= grant_d;
                  if (sel_status == ST_OK) begin
                     state   <= ADDR;
                     cnt     <= '0;
                     m_req   <= 1'b1;
                     m_wen   <= sel_wen;
                     m_addr  <= sel_addr;
                     m_size  <= sel_size;
                     m_strb  <= sel_strb;
                     m_wdata <= sel_wdata;
                  end else begin
                     state <= RESP;
                  end
               end
            end
            ADDR: begin
               if (m_addr_ok) begin
                  m_req <= 1'b0;
                  if (m_data_ok) begin
                     state <= RESP;
                  end else begin
                     state <= DATA;
                     cnt   <= '0;
                  end
               end else if (timeout_hit) begin
                  m_req <= 1'b0;
                  state <= RESP;
               end else if (TIMEOUT != 0) begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (m_data_ok || timeout_hit) begin
                  state <= RESP;
               end else if (TIMEOUT != 0) begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Registered one-cycle response to the owning requester; cleared in RESP.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         i_resp_valid <= 1'b0;
         i_rdata      <= 32'h0;
         i_status     <= 2'b00;
         d_resp_valid <= 1'b0;
         d_rdata      <= 32'h0;
         d_status     <= 2'b00;
      end else begin
         i_resp_valid <= fin & ~fin_owner_d;
         i_rdata      <= (fin & ~fin_owner_d) ? fin_rdata : 32'h0;
         i_status     <= (fin & ~fin_owner_d) ? fin_status : ST_OK;
         d_resp_valid <= fin & fin_owner_d;
         d_rdata      <= (fin & fin_owner_d) ? fin_rdata : 32'h0;
         d_status     <= (fin & fin_owner_d) ? fin_status : ST_OK;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for mem_port_arbiter (TIMEOUT=4).
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        i_req, d_req, d_wen;
   logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
   logic [1:0]  d_size;
   logic        m_addr_ok, m_data_ok;
   logic        i_ready, i_resp_valid, d_ready, d_resp_valid;
   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic [1:0]  i_status, d_status, m_size;
   logic        m_req, m_wen;
   logic [3:0]  m_strb;

   int total = 0;
   int bad   = 0;

   mem_port_arbiter #(.TIMEOUT(4)) dut (
      .clk(clk), .resetn(resetn),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
      .i_resp_valid(i_resp_valid), .i_rdata(i_rdata), .i_status(i_status),
      .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_size(d_size),
      .d_wdata(d_wdata), .d_ready(d_ready), .d_resp_valid(d_resp_valid),
      .d_rdata(d_rdata), .d_status(d_status),
      .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_size(m_size),
      .m_strb(m_strb), .m_wdata(m_wdata),
      .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_d;
      logic        wen;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      int          ok_at;       // cycle after accept that m_addr_ok pulses (0 = never)
      int          dok_at;      // cycle after accept that m_data_ok pulses (0 = never)
      logic [31:0] mrdata;
      int          exp_k;       // cycle after accept that resp_valid is expected
      logic [1:0]  exp_status;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_strb;
      int          exp_mreq_n;  // number of cycles m_req is high
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic is_d, input logic wen, input logic [31:0] addr,
                               input logic [1:0] size, input logic [31:0] wdata,
                               input int ok_at, input int dok_at, input logic [31:0] mrdata,
                               input int exp_k, input logic [1:0] exp_status,
                               input logic [31:0] exp_rdata, input logic [3:0] exp_strb,
                               input int exp_mreq_n);
      vec_t v;
      v.is_d = is_d; v.wen = wen; v.addr = addr; v.size = size; v.wdata = wdata;
      v.ok_at = ok_at; v.dok_at = dok_at; v.mrdata = mrdata; v.exp_k = exp_k;
      v.exp_status = exp_status; v.exp_rdata = exp_rdata; v.exp_strb = exp_strb;
      v.exp_mreq_n = exp_mreq_n;
      return v;
   endfunction

   // Called just after a rising edge in an IDLE cycle; returns just after the
   // rising edge that ends the response cycle.
   task automatic run_vec(input vec_t v, input int idx);
      int  k;
      int  mreq_n;
      bit  got;
      if (v.is_d) begin
         d_req = 1'b1; d_wen = v.wen; d_addr = v.addr; d_size = v.size; d_wdata = v.wdata;
      end else begin
         i_req = 1'b1; i_addr = v.addr;
      end
      #1;
      check($sformatf("v%0d_ready", idx), v.is_d ? d_ready : i_ready, 1);
      @(posedge clk); #1;
      i_req = 1'b0; d_req = 1'b0;
      mreq_n = 0; got = 0; k = 1;
      while (!got && k <= 20) begin
         m_addr_ok = (k == v.ok_at);
         m_data_ok = (k == v.dok_at);
         m_rdata   = (k == v.dok_at) ? v.mrdata : 32'hDEAD_BEEF;
         #1;
         if (k == 1 && v.exp_mreq_n > 0) begin
            check($sformatf("v%0d_m_addr", idx), m_addr, v.addr);
            check($sformatf("v%0d_m_wen", idx), m_wen, v.wen);
            check($sformatf("v%0d_m_size", idx), m_size, v.size);
            check($sformatf("v%0d_m_strb", idx), m_strb, v.exp_strb);
            check($sformatf("v%0d_m_wdata", idx), m_wdata, v.wdata);
         end
         if (m_req) mreq_n++;
         if (i_resp_valid || d_resp_valid) begin
            got = 1;
            check($sformatf("v%0d_resp_cycle", idx), k, v.exp_k);
            check($sformatf("v%0d_owner_valid", idx), v.is_d ? d_resp_valid : i_resp_valid, 1);
            check($sformatf("v%0d_other_valid", idx), v.is_d ? i_resp_valid : d_resp_valid, 0);
            check($sformatf("v%0d_status", idx), v.is_d ? d_status : i_status, v.exp_status);
            check($sformatf("v%0d_rdata", idx), v.is_d ? d_rdata : i_rdata, v.exp_rdata);
         end
         @(posedge clk); #1;
         k++;
      end
      m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;
      if (!got) check($sformatf("v%0d_resp_seen", idx), 0, 1);
      check($sformatf("v%0d_mreq_cycles", idx), mreq_n, v.exp_mreq_n);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit exp_d;
      int ng;

      vecs[0]  = mk(0, 0, 32'hBFC0_0000, 2, 32'h0,         1, 4, 32'h3C08_BFC0, 5, 2'b00, 32'h3C08_BFC0, 4'b0000, 1);
      vecs[1]  = mk(1, 1, 32'h0000_1003, 1, 32'h0000_1100, 0, 0, 32'h0,         1, 2'b01, 32'h0,         4'b0000, 0);
      vecs[2]  = mk(1, 0, 32'h0000_0002, 2, 32'h0,         0, 0, 32'h0,         1, 2'b01, 32'h0,         4'b0000, 0);
      vecs[3]  = mk(1, 1, 32'h0000_0006, 0, 32'h00AB_0000, 1, 1, 32'hFFFF_FFFF, 2, 2'b00, 32'h0,         4'b0100, 1);
      vecs[4]  = mk(1, 0, 32'h0000_0000, 3, 32'h0,         0, 0, 32'h0,         1, 2'b11, 32'h0,         4'b0000, 0);
      vecs[5]  = mk(1, 0, 32'h0000_0100, 2, 32'h0,         2, 3, 32'h1234_5678, 4, 2'b00, 32'h1234_5678, 4'b0000, 2);
      vecs[6]  = mk(1, 1, 32'h0000_0202, 1, 32'hBEEF_0000, 1, 2, 32'h5555_5555, 3, 2'b00, 32'h0,         4'b1100, 1);
      vecs[7]  = mk(1, 0, 32'h0000_0003, 0, 32'h0,         3, 3, 32'h0000_CAFE, 4, 2'b00, 32'h0000_CAFE, 4'b0000, 3);
      vecs[8]  = mk(1, 1, 32'h0000_0010, 2, 32'hA5A5_A5A5, 1, 1, 32'h0,         2, 2'b00, 32'h0,         4'b1111, 1);
      vecs[9]  = mk(1, 0, 32'h0000_0040, 2, 32'h0,         0, 0, 32'h0,         5, 2'b10, 32'h0,         4'b0000, 4);
      vecs[10] = mk(0, 0, 32'h0000_0002, 2, 32'h0,         0, 0, 32'h0,         1, 2'b01, 32'h0,         4'b0000, 0);
      vecs[11] = mk(1, 0, 32'h0000_0044, 2, 32'h0,         1, 0, 32'h0,         6, 2'b10, 32'h0,         4'b0000, 1);
      vecs[12] = mk(1, 0, 32'h0000_0048, 2, 32'h0,         4, 4, 32'h7766_5544, 5, 2'b00, 32'h7766_5544, 4'b0000, 4);

      // Reset with both requesters active: everything must read 0.
      resetn = 1'b0;
      i_req = 1'b1; i_addr = 32'h0000_0080;
      d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_0040; d_size = 2'd2; d_wdata = 32'h0;
      m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;
      #12;
      check("rst_i_ready", i_ready, 0);
      check("rst_d_ready", d_ready, 0);
      check("rst_m_req", m_req, 0);
      check("rst_resp_valid", {i_resp_valid, d_resp_valid}, 0);
      check("rst_status", {i_status, d_status}, 0);
      @(posedge clk); #1;
      resetn = 1'b1;

      // Both requesters held from reset with an always-ready memory:
      // grants must go D, I, D, I, ...
      m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h1111_2222;
      exp_d = 1'b1; ng = 0;
      for (int c = 0; c < 14; c++) begin
         #1;
         if (i_ready || d_ready) begin
            check("arb_single_ready", i_ready & d_ready, 0);
            check($sformatf("arb_grant%0d", ng), d_ready, exp_d);
            exp_d = ~exp_d;
            ng++;
         end
         @(posedge clk); #1;
      end
      check("arb_grant_count", ng, 5);
      i_req = 1'b0; d_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;

      for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

      // Reset while waiting in ADDR: m_req drops without a clock edge.
      d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_0020; d_size = 2'd2; d_wdata = 32'h0;
      #1;
      check("ra_ready", d_ready, 1);
      @(posedge clk); #1;
      check("ra_m_req_before", m_req, 1);
      #2;
      resetn = 1'b0;
      #1;
      check("ra_m_req_after", m_req, 0);
      check("ra_m_addr_after", m_addr, 0);
      check("ra_d_ready_in_reset", d_ready, 0);
      resetn = 1'b1;
      d_req = 1'b0;
      @(posedge clk); #1;

      // Reset while waiting in DATA: all outputs back to 0 immediately.
      d_req = 1'b1;
      #1;
      check("rd_ready", d_ready, 1);
      @(posedge clk); #1;
      d_req = 1'b0;
      m_addr_ok = 1'b1;
      @(posedge clk); #1;
      m_addr_ok = 1'b0;
      #1;
      check("rd_in_data_m_req", m_req, 0);
      check("rd_in_data_m_addr", m_addr, 32'h0000_0020);
      d_req = 1'b1;
      resetn = 1'b0;
      #1;
      check("rd_m_addr_after", m_addr, 0);
      check("rd_m_size_after", m_size, 0);
      check("rd_d_ready_in_reset", d_ready, 0);
      check("rd_resp_after", {i_resp_valid, d_resp_valid}, 0);
      resetn = 1'b1;
      d_req = 1'b0;
      @(posedge clk); #1;
      check("rd_m_req_idle", m_req, 0);

      // First request after release is accepted straight from IDLE.
      run_vec(mk(0, 0, 32'h0000_0100, 2, 32'h0, 1, 1, 32'h0BAD_F00D, 2, 2'b00, 32'h0BAD_F00D, 4'b0000, 1), 13);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
